// File: rtl/imem_loader_pkg.sv
// ============================================================================
// imem_loader_pkg
// Shared state encoding and default sizing for the instruction-memory loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

    localparam int C_ADDR_W_DEFAULT  = 6;
    localparam int C_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LEN   = 3'd1,
        LDR_DATA  = 3'd2,
        LDR_CHECK = 3'd3,
        LDR_DONE  = 3'd4,
        LDR_ERR   = 3'd5
    } ldr_state_t;

endpackage

`default_nettype wire

// File: rtl/imem_word_packer.sv
// ============================================================================
// imem_word_packer
// Assembles four little-endian bytes into a 32-bit word, pulsing word_valid
// combinationally with the fourth byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  r_idx;
    logic [23:0] r_low;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_idx <= '0;
            r_low <= '0;
        end else if (byte_valid) begin
            r_idx <= r_idx + 2'd1;
            case (r_idx)
                2'd0:    r_low[7:0]   <= byte_data;
                2'd1:    r_low[15:8]  <= byte_data;
                2'd2:    r_low[23:16] <= byte_data;
                default: r_low        <= '0;
            endcase
        end
    end

    // Top byte bypasses the register so the loader can write the word on the next edge.
    assign word_valid = byte_valid && !clear && (r_idx == 2'd3);
    assign word_data  = {byte_data, r_low};

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader
// Byte-stream loader for instruction memory: length, words, XOR checksum.
// Holds the CPU until a complete, verified image has been written.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W_DEFAULT,
    parameter int TIMEOUT = C_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  C_IDLE_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0]  C_IDLE_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   C_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_WL_ONE    = (ADDR_W + 1)'(1);

    ldr_state_t        r_state;
    logic [ADDR_W:0]   r_num;
    logic [7:0]        r_chk;
    logic [CNT_W-1:0]  r_idle;

    logic              w_accept;
    logic              w_arm;
    logic              w_loading;
    logic              w_timeout;
    logic              w_word_valid;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_wl_next;

    assign w_accept  = rx_valid && rx_ready;
    assign w_arm     = start && (r_state == LDR_IDLE || r_state == LDR_DONE || r_state == LDR_ERR);
    assign w_loading = (r_state == LDR_LEN) || (r_state == LDR_DATA) || (r_state == LDR_CHECK);
    assign w_timeout = (TIMEOUT != 0) && w_loading && !w_accept && (r_idle == C_IDLE_LAST);
    assign w_wl_next = words_loaded + C_WL_ONE;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_arm || w_timeout),
        .byte_valid (w_accept && (r_state == LDR_DATA)),
        .byte_data  (rx_data),
        .word_valid (w_word_valid),
        .word_data  (w_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= LDR_IDLE;
            r_num        <= '0;
            r_chk        <= '0;
            r_idle       <= '0;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            if (w_loading) begin
                r_idle <= w_accept ? '0 : r_idle + C_IDLE_ONE;
            end

            if (w_timeout) begin
                r_state  <= LDR_ERR;
                error    <= 1'b1;
                rx_ready <= 1'b0;
            end else begin
                case (r_state)
                    LDR_IDLE, LDR_DONE, LDR_ERR: begin
                        if (start) begin
                            r_state      <= LDR_LEN;
                            rx_ready     <= 1'b1;
                            done         <= 1'b0;
                            error        <= 1'b0;
                            cpu_hold     <= 1'b1;
                            words_loaded <= '0;
                            r_chk        <= '0;
                            r_idle       <= '0;
                            mem_addr     <= '0;
                        end
                    end
                    LDR_LEN: begin
                        if (w_accept) begin
                            if (int'(rx_data) > DEPTH) begin
                                r_state  <= LDR_ERR;
                                error    <= 1'b1;
                                rx_ready <= 1'b0;
                            end else begin
                                r_num   <= (rx_data == 8'd0) ? C_DEPTH : (ADDR_W + 1)'(rx_data);
                                r_state <= LDR_DATA;
                            end
                        end
                    end
                    LDR_DATA: begin
                        if (w_accept) begin
                            r_chk <= r_chk ^ rx_data;
                            if (w_word_valid) begin
                                mem_we       <= 1'b1;
                                mem_wdata    <= w_word;
                                mem_addr     <= words_loaded[ADDR_W-1:0];
                                words_loaded <= w_wl_next;
                                if (w_wl_next == r_num) begin
                                    r_state <= LDR_CHECK;
                                end
                            end
                        end
                    end
                    LDR_CHECK: begin
                        if (w_accept) begin
                            rx_ready <= 1'b0;
                            if (rx_data == r_chk) begin
                                r_state  <= LDR_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                r_state <= LDR_ERR;
                                error   <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state  <= LDR_IDLE;
                        rx_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader
// Self-checking bench: directed table, hand sequences and random loads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    typedef struct {
        int len;
        bit good;
        int maxgap;
        bit idx_data;
        bit exp_done;
        bit exp_err;
        int exp_words;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_at = -1;
    logic [7:0] bq[$];
    int   gq[$];
    int   acc_q[$];
    wr_t  got_q[$];
    wr_t  exp_q[$];
    bit   m_done;
    bit   m_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (rst === 1'b1 && mem_we === 1'b1) begin
            w.addr = mem_addr;
            w.data = mem_wdata;
            w.cyc  = cyc;
            got_q.push_back(w);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: outcome of a load derived directly from the stream and its gaps.
    task automatic model();
        int cut;
        int len;
        int n;
        logic [7:0] x;
        wr_t w;
        exp_q.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        cut = bq.size();
        for (int k = 0; k < bq.size(); k++) begin
            if (gq[k] >= TIMEOUT) begin
                cut = k;
                break;
            end
        end
        if (cut == 0) begin m_err = 1'b1; return; end
        len = int'(bq[0]);
        if (len > DEPTH) begin m_err = 1'b1; return; end
        n = (len == 0) ? DEPTH : len;
        for (int i = 0; i < n; i++) begin
            if (4 * i + 4 < cut) begin
                w.addr = ADDR_W'(i);
                w.data = {bq[4*i+4], bq[4*i+3], bq[4*i+2], bq[4*i+1]};
                w.cyc  = 4 * i + 4;
                exp_q.push_back(w);
            end
        end
        if (cut < bq.size()) begin m_err = 1'b1; return; end
        x = 8'h00;
        for (int k = 1; k <= 4 * n; k++) x ^= bq[k];
        if (bq[4*n+1] == x) m_done = 1'b1;
        else                m_err  = 1'b1;
    endtask

    task automatic build(input int len, input bit good, input int maxgap, input int stall, input bit idx_data);
        int n;
        logic [7:0] x;
        logic [31:0] wd;
        bq.delete();
        gq.delete();
        bq.push_back(8'(len));
        if (len <= DEPTH) begin
            n = (len == 0) ? DEPTH : len;
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                wd = idx_data ? 32'(i) : $urandom;
                for (int b = 0; b < 4; b++) begin
                    bq.push_back(wd[8*b +: 8]);
                    x ^= wd[8*b +: 8];
                end
            end
            bq.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
        end
        for (int k = 0; k < bq.size(); k++) gq.push_back($urandom_range(0, maxgap));
        if (stall >= 0 && stall < gq.size()) gq[stall] = TIMEOUT;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered and left on a negedge; each accepted byte logs its posedge count.
    task automatic drive();
        int n;
        for (int k = 0; k < bq.size(); k++) begin
            rx_valid = 1'b0;
            if (k == start_at) pulse_start();
            repeat (gq[k]) @(negedge clk);
            if (gq[k] >= TIMEOUT) return;
            rx_valid = 1'b1;
            rx_data  = bq[k];
            n = 0;
            while (rx_ready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                checks++;
                errors++;
                $display("FAIL rx_ready_wait: byte %0d never accepted, rx_ready=%b required 1", k, rx_ready);
                rx_valid = 1'b0;
                return;
            end
            @(negedge clk);
            acc_q.push_back(cyc);
        end
        rx_valid = 1'b0;
    endtask

    task automatic run_load(input string tag);
        model();
        got_q.delete();
        acc_q.delete();
        pulse_start();
        drive();
        chk({tag, "_done"}, done, m_done);
        chk({tag, "_error"}, error, m_err);
        chk({tag, "_cpu_hold"}, cpu_hold, !m_done);
        chk({tag, "_words_loaded"}, words_loaded, exp_q.size());
        chk({tag, "_rx_ready"}, rx_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk({tag, "_nwrites"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_waddr"}, got_q[i].addr, exp_q[i].addr);
            chk({tag, "_wdata"}, got_q[i].data, exp_q[i].data);
            if (exp_q[i].cyc < acc_q.size())
                chk({tag, "_wlatency"}, got_q[i].cyc, acc_q[exp_q[i].cyc]);
        end
    endtask

    task automatic set_case1(input logic [7:0] c);
        logic [7:0] s[10];
        s = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        s[9] = c;
        bq.delete();
        gq.delete();
        for (int k = 0; k < 10; k++) begin
            bq.push_back(s[k]);
            gq.push_back(0);
        end
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{len: 2,   good: 1, maxgap: 0,           idx_data: 0, exp_done: 1, exp_err: 0, exp_words: 2};
        tbl[1] = '{len: 2,   good: 0, maxgap: 0,           idx_data: 0, exp_done: 0, exp_err: 1, exp_words: 2};
        tbl[2] = '{len: 65,  good: 1, maxgap: 0,           idx_data: 0, exp_done: 0, exp_err: 1, exp_words: 0};
        tbl[3] = '{len: 0,   good: 1, maxgap: 0,           idx_data: 1, exp_done: 1, exp_err: 0, exp_words: 64};
        tbl[4] = '{len: 64,  good: 1, maxgap: 2,           idx_data: 0, exp_done: 1, exp_err: 0, exp_words: 64};
        tbl[5] = '{len: 1,   good: 1, maxgap: TIMEOUT - 1, idx_data: 0, exp_done: 1, exp_err: 0, exp_words: 1};
        tbl[6] = '{len: 255, good: 1, maxgap: 0,           idx_data: 0, exp_done: 0, exp_err: 1, exp_words: 0};
        tbl[7] = '{len: 7,   good: 0, maxgap: 5,           idx_data: 0, exp_done: 0, exp_err: 1, exp_words: 7};

        repeat (3) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_cpu_hold", cpu_hold, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_words_loaded", words_loaded, '0);

        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h02;
        repeat (3) @(negedge clk);
        chk("idle_rx_ready", rx_ready, 1'b0);
        rx_valid = 1'b0;

        // XOR of the eight data bytes is 0x2A.
        set_case1(8'h2A);
        run_load("case1");
        chk("case1_w0", (got_q.size() > 0) ? {26'd0, got_q[0].addr, got_q[0].data} : 64'hX, {32'd0, 32'h12345678});
        chk("case1_w1", (got_q.size() > 1) ? {26'd0, got_q[1].addr, got_q[1].data} : 64'hX, {32'd1, 32'hDEADBEEF});
        chk("case1_done", done, 1'b1);
        chk("case1_words", words_loaded, 7'd2);

        set_case1(8'h00);
        run_load("case2");
        chk("case2_error", error, 1'b1);
        chk("case2_nwrites", got_q.size(), 2);

        for (int t = 0; t < 8; t++) begin
            build(tbl[t].len, tbl[t].good, tbl[t].maxgap, -1, tbl[t].idx_data);
            run_load("tbl");
            chk("tbl_done", done, tbl[t].exp_done);
            chk("tbl_error", error, tbl[t].exp_err);
            chk("tbl_words", words_loaded, tbl[t].exp_words);
        end

        build(2, 1, 0, 2, 0);
        run_load("stall");
        chk("stall_error", error, 1'b1);
        chk("stall_nwrites", got_q.size(), 0);

        build(2, 1, 0, -1, 0);
        gq[2] = TIMEOUT - 1;
        gq[7] = TIMEOUT - 1;
        run_load("nearstall");
        chk("nearstall_done", done, 1'b1);

        set_case1(8'h2A);
        start_at = 3;
        run_load("midstart");
        start_at = -1;
        chk("midstart_done", done, 1'b1);

        // Abort partway through the first word.
        set_case1(8'h2A);
        bq = bq[0:3];
        got_q.delete();
        acc_q.delete();
        pulse_start();
        drive();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rx_ready", rx_ready, 1'b0);
        chk("midrst_mem_we", mem_we, 1'b0);
        chk("midrst_mem_addr", mem_addr, '0);
        chk("midrst_mem_wdata", mem_wdata, 32'h0);
        chk("midrst_cpu_hold", cpu_hold, 1'b1);
        chk("midrst_done", done, 1'b0);
        chk("midrst_error", error, 1'b0);
        chk("midrst_words", words_loaded, '0);
        chk("midrst_nwrites", got_q.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        set_case1(8'h2A);
        run_load("reload");
        chk("reload_done", done, 1'b1);

        for (int r = 0; r < 8; r++) begin
            build($urandom_range(1, 8), ($urandom_range(0, 3) != 0), $urandom_range(0, TIMEOUT - 1),
                  ($urandom_range(0, 4) == 0) ? $urandom_range(1, 12) : -1, 1'b0);
            run_load("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, got running required finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
